tx_fire_sequencer: RTL and testbench

- Upstream stage of the transducer output controller.
- Turns one software start request into a train of N fire shots at a programmed repetition period.
- Drives the controller's 8-bit control command (IDLE=8'h00 / FIRE=8'h01) and the two charge times, holding both stable for each shot.
- Monitors the controller's ADC trigger line to confirm each shot's ADC handshake completed; reports shot progress and a sticky ack-miss error.

---
 rtl/tx_fire_sequencer_pkg.sv | 18 +
 rtl/tx_fire_sequencer_ack_mon.sv | 36 +++
 rtl/tx_fire_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_tx_fire_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_fire_sequencer_pkg.sv
// Shared definitions for the transmit fire sequencer and the output controller.
package tx_fire_sequencer_pkg;

    // Default charge-time width; it must match the controller's charge-time inputs.
    localparam int CT_W_DEF = 9;

    // Command codes understood by the output controller.
    localparam logic [7:0] CMD_IDLE = 8'h00;
    localparam logic [7:0] CMD_FIRE = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/tx_fire_sequencer_ack_mon.sv
// Per-shot ADC handshake tracker: a shot is acknowledged once the trigger
// line has been seen high and then low again while FIRE is being driven.
module adc_ack_monitor (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic shot_start_i,
    input  logic eval_i,
    input  logic fire_i,
    input  logic trig_i,
    output logic ack_ok_o
);

    logic saw_hi_q;
    logic ack_ok_q;

    // Track the high-then-low pattern; the evaluation cycle also clears for the next shot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            saw_hi_q <= 1'b0;
            ack_ok_q <= 1'b0;
        end else if (clear_i || shot_start_i || eval_i) begin
            saw_hi_q <= 1'b0;
            ack_ok_q <= 1'b0;
        end else if (fire_i) begin
            if (trig_i) begin
                saw_hi_q <= 1'b1;
            end else if (saw_hi_q) begin
                ack_ok_q <= 1'b1;
            end
        end
    end

    assign ack_ok_o = ack_ok_q;

endmodule

// File: rtl/tx_fire_sequencer.sv
// Turns one start request into a train of fire shots at a programmed period.
//   state   | meaning
//   IDLE    | waiting for iStart; outputs hold results of the last sequence
//   FIRE    | FIRE command driven, pcnt 0..FIRE_HOLD-1 of the current shot
//   GAP     | IDLE command driven, pcnt FIRE_HOLD..P-1 of the current shot
//   DONE    | end-of-sequence report (oDone pulse), then back to IDLE
module tx_fire_sequencer
    import tx_fire_sequencer_pkg::*;
#(
    parameter int CT_W       = CT_W_DEF,
    parameter int SHOT_W     = 16,
    parameter int PER_W      = 24,
    parameter int FIRE_HOLD  = 520,
    parameter int MIN_PERIOD = FIRE_HOLD + 2
) (
    input  logic              txCLK,
    input  logic              txRESETn,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic [SHOT_W-1:0] iNumShots,
    input  logic [PER_W-1:0]  iPeriod,
    input  logic [CT_W-1:0]   iChargeTime1,
    input  logic [CT_W-1:0]   iChargeTime2,
    input  logic              iADCTriggerLine,
    output logic [7:0]        oControlComms,
    output logic [CT_W-1:0]   oChargeTime1,
    output logic [CT_W-1:0]   oChargeTime2,
    output logic              oBusy,
    output logic              oDone,
    output logic              oAborted,
    output logic [SHOT_W-1:0] oShotCount,
    output logic              oAckMiss
);

    state_e            state_q, state_d;
    logic [PER_W-1:0]  pcnt_q, pcnt_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [SHOT_W-1:0] nshot_q, nshot_d;
    logic [SHOT_W-1:0] cnt_q, cnt_d;
    logic [CT_W-1:0]   ct1_q, ct1_d;
    logic [CT_W-1:0]   ct2_q, ct2_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              miss_q, miss_d;
    logic              start_shot;
    logic              ack_ok;
    logic              abort_now;
    logic              fire_end;
    logic              gap_end;
    logic [SHOT_W-1:0] cnt_inc;
    logic [PER_W-1:0]  per_clamp;

    assign abort_now = iAbort && ((state_q == ST_FIRE) || (state_q == ST_GAP));
    assign fire_end  = (state_q == ST_FIRE) && (pcnt_q == PER_W'(FIRE_HOLD - 1));
    assign gap_end   = (state_q == ST_GAP) && (pcnt_q == per_q - PER_W'(1));
    assign cnt_inc   = cnt_q + SHOT_W'(1);
    assign per_clamp = (iPeriod < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : iPeriod;

    adc_ack_monitor u_ack_mon (
        .clk_i        (txCLK),
        .rst_ni       (txRESETn),
        .clear_i      ((state_q == ST_IDLE) || (state_q == ST_DONE) || abort_now),
        .shot_start_i (start_shot),
        .eval_i       (fire_end),
        .fire_i       (state_q == ST_FIRE),
        .trig_i       (iADCTriggerLine),
        .ack_ok_o     (ack_ok)
    );

    // Sequencing: abort has priority over the shot timing in FIRE and GAP.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        per_d      = per_q;
        nshot_d    = nshot_q;
        cnt_d      = cnt_q;
        ct1_d      = ct1_q;
        ct2_d      = ct2_q;
        cmd_d      = cmd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        aborted_d  = aborted_q;
        miss_d     = miss_q;
        start_shot = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    nshot_d   = iNumShots;
                    per_d     = per_clamp;
                    ct1_d     = iChargeTime1;
                    ct2_d     = iChargeTime2;
                    cnt_d     = '0;
                    miss_d    = 1'b0;
                    aborted_d = 1'b0;
                    busy_d    = 1'b1;
                    pcnt_d    = '0;
                    if (iNumShots == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_FIRE;
                        cmd_d      = CMD_FIRE;
                        start_shot = 1'b1;
                    end
                end
            end
            ST_FIRE, ST_GAP: begin
                if (abort_now) begin
                    state_d   = ST_DONE;
                    cmd_d     = CMD_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (fire_end) begin
                    state_d = ST_GAP;
                    cmd_d   = CMD_IDLE;
                    pcnt_d  = pcnt_q + PER_W'(1);
                    if (!ack_ok) begin
                        miss_d = 1'b1;
                    end
                end else if (gap_end) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == nshot_q) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_FIRE;
                        cmd_d      = CMD_FIRE;
                        pcnt_d     = '0;
                        start_shot = 1'b1;
                    end
                end else begin
                    pcnt_d = pcnt_q + PER_W'(1);
                end
            end
            ST_DONE: begin
                // A zero-shot request arrives here with the pulse still to be issued.
                if (!done_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge txCLK or negedge txRESETn) begin
        if (!txRESETn) begin
            state_q   <= ST_IDLE;
            pcnt_q    <= '0;
            per_q     <= '0;
            nshot_q   <= '0;
            cnt_q     <= '0;
            ct1_q     <= '0;
            ct2_q     <= '0;
            cmd_q     <= CMD_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            per_q     <= per_d;
            nshot_q   <= nshot_d;
            cnt_q     <= cnt_d;
            ct1_q     <= ct1_d;
            ct2_q     <= ct2_d;
            cmd_q     <= cmd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            miss_q    <= miss_d;
        end
    end

    assign oControlComms = cmd_q;
    assign oChargeTime1  = ct1_q;
    assign oChargeTime2  = ct2_q;
    assign oBusy         = busy_q;
    assign oDone         = done_q;
    assign oAborted      = aborted_q;
    assign oShotCount    = cnt_q;
    assign oAckMiss      = miss_q;

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// Self-checking bench for tx_fire_sequencer: sequence table plus reset corner cases.
module tb_tx_fire_sequencer;

    localparam int CT_W       = 9;
    localparam int SHOT_W     = 16;
    localparam int PER_W      = 24;
    localparam int FIRE_HOLD  = 520;
    localparam int MIN_PERIOD = FIRE_HOLD + 2;

    logic              txCLK;
    logic              txRESETn;
    logic              iStart;
    logic              iAbort;
    logic [SHOT_W-1:0] iNumShots;
    logic [PER_W-1:0]  iPeriod;
    logic [CT_W-1:0]   iChargeTime1;
    logic [CT_W-1:0]   iChargeTime2;
    logic              iADCTriggerLine;
    logic [7:0]        oControlComms;
    logic [CT_W-1:0]   oChargeTime1;
    logic [CT_W-1:0]   oChargeTime2;
    logic              oBusy;
    logic              oDone;
    logic              oAborted;
    logic [SHOT_W-1:0] oShotCount;
    logic              oAckMiss;

    tx_fire_sequencer #(
        .CT_W      (CT_W),
        .SHOT_W    (SHOT_W),
        .PER_W     (PER_W),
        .FIRE_HOLD (FIRE_HOLD)
    ) dut (
        .txCLK           (txCLK),
        .txRESETn        (txRESETn),
        .iStart          (iStart),
        .iAbort          (iAbort),
        .iNumShots       (iNumShots),
        .iPeriod         (iPeriod),
        .iChargeTime1    (iChargeTime1),
        .iChargeTime2    (iChargeTime2),
        .iADCTriggerLine (iADCTriggerLine),
        .oControlComms   (oControlComms),
        .oChargeTime1    (oChargeTime1),
        .oChargeTime2    (oChargeTime2),
        .oBusy           (oBusy),
        .oDone           (oDone),
        .oAborted        (oAborted),
        .oShotCount      (oShotCount),
        .oAckMiss        (oAckMiss)
    );

    initial txCLK = 1'b0;
    always #5 txCLK = ~txCLK;

    // Sequence description and the results expected at its oDone pulse.
    typedef struct {
        int n;
        int per;
        int ct1;
        int ct2;
        bit stuck;
        bit abort_with_start;
        int abort_cyc;
        int exp_done;
        int exp_shots;
        bit exp_miss;
        bit exp_abort;
    } vec_t;

    typedef struct {
        int done_cyc;
        int shots;
        bit miss;
        bit aborted;
    } sb_t;

    vec_t vecs[5];
    sb_t  sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycle c is the interval after the c-th rising edge counted from the edge that samples iStart.
    task automatic run_vec(input vec_t v, input int idx);
        int    pe;
        int    cmd_err;
        int    busy_err;
        int    ct_err;
        int    fcnt;
        int    budget;
        int    k;
        int    off;
        bit    seen;
        logic  exp_cmd;
        sb_t   e;
        string tag;
        pe       = (v.per < MIN_PERIOD) ? MIN_PERIOD : v.per;
        cmd_err  = 0;
        busy_err = 0;
        ct_err   = 0;
        fcnt     = 0;
        seen     = 1'b0;
        budget   = v.exp_done + 20;
        tag      = $sformatf("v%0d", idx);
        sb_q.push_back('{v.exp_done, v.exp_shots, v.exp_miss, v.exp_abort});

        @(negedge txCLK);
        iNumShots       = SHOT_W'(v.n);
        iPeriod         = PER_W'(v.per);
        iChargeTime1    = CT_W'(v.ct1);
        iChargeTime2    = CT_W'(v.ct2);
        iStart          = 1'b1;
        iAbort          = v.abort_with_start;
        iADCTriggerLine = v.stuck;

        for (int c = 1; c <= budget && !seen; c++) begin
            @(negedge txCLK);
            iStart = (c == 700);
            iAbort = (c == v.abort_cyc);
            if (c == 2) begin
                iChargeTime1 = CT_W'(v.ct1 ^ 'h1ff);
                iChargeTime2 = CT_W'(v.ct2 ^ 'h155);
            end
            k       = (c - 1) / pe;
            off     = (c - 1) % pe;
            exp_cmd = (k < v.n) && (off < FIRE_HOLD) && (v.abort_cyc == 0 || c <= v.abort_cyc);
            if (oControlComms !== {7'd0, exp_cmd}) cmd_err++;
            if (oBusy !== (c < v.exp_done)) busy_err++;
            if (oChargeTime1 !== CT_W'(v.ct1) || oChargeTime2 !== CT_W'(v.ct2)) ct_err++;
            if (c == 522) chk({tag, " ackmiss_after_shot1"}, oAckMiss, v.exp_miss);
            if (oDone === 1'b1) begin
                seen = 1'b1;
                e = sb_q.pop_front();
                chk({tag, " done_cycle"}, c, e.done_cyc);
                chk({tag, " shot_count"}, oShotCount, e.shots);
                chk({tag, " ack_miss"}, oAckMiss, e.miss);
                chk({tag, " aborted"}, oAborted, e.aborted);
            end
            if (v.stuck) begin
                iADCTriggerLine = 1'b1;
            end else begin
                fcnt = (oControlComms == 8'h01) ? fcnt + 1 : 0;
                iADCTriggerLine = (fcnt >= 3) && (fcnt <= 5);
            end
        end
        if (!seen) begin
            e = sb_q.pop_front();
            chk({tag, " done_timeout"}, 0, 1);
        end
        chk({tag, " cmd_trace_errors"}, cmd_err, 0);
        chk({tag, " busy_trace_errors"}, busy_err, 0);
        chk({tag, " charge_time_errors"}, ct_err, 0);
        @(negedge txCLK);
        chk({tag, " done_one_cycle"}, oDone, 0);
        iStart          = 1'b0;
        iAbort          = 1'b0;
        iADCTriggerLine = 1'b0;
        repeat (3) @(negedge txCLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          n  per   ct1 ct2 stk aws abort done shots miss abt
        vecs[0] = '{3, 1000, 100, 200, 0, 0, 0,    3001, 3, 0, 0};
        vecs[1] = '{0, 1000, 5,   6,   0, 0, 0,    2,    0, 0, 0};
        vecs[2] = '{2, 100,  300, 400, 0, 0, 0,    1045, 2, 0, 0};
        vecs[3] = '{2, 600,  77,  88,  1, 1, 0,    1201, 2, 1, 0};
        vecs[4] = '{5, 1000, 10,  20,  0, 0, 1200, 1201, 1, 0, 1};

        txRESETn        = 1'b0;
        iStart          = 1'b0;
        iAbort          = 1'b0;
        iNumShots       = '0;
        iPeriod         = '0;
        iChargeTime1    = '0;
        iChargeTime2    = '0;
        iADCTriggerLine = 1'b0;
        repeat (3) @(negedge txCLK);
        chk("reset cmd", oControlComms, 8'h00);
        chk("reset ct1", oChargeTime1, 0);
        chk("reset ct2", oChargeTime2, 0);
        chk("reset busy", oBusy, 0);
        chk("reset done", oDone, 0);
        chk("reset aborted", oAborted, 0);
        chk("reset shot_count", oShotCount, 0);
        chk("reset ack_miss", oAckMiss, 0);
        txRESETn = 1'b1;
        iAbort   = 1'b1;
        @(negedge txCLK);
        iAbort = 1'b0;
        @(negedge txCLK);
        chk("idle abort ignored busy", oBusy, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Asynchronous reset in the middle of a FIRE window.
        @(negedge txCLK);
        iNumShots    = SHOT_W'(3);
        iPeriod      = PER_W'(1000);
        iChargeTime1 = CT_W'(100);
        iChargeTime2 = CT_W'(200);
        iStart       = 1'b1;
        @(negedge txCLK);
        iStart = 1'b0;
        repeat (99) @(negedge txCLK);
        chk("pre_reset cmd", oControlComms, 8'h01);
        chk("pre_reset busy", oBusy, 1);
        #2;
        txRESETn = 1'b0;
        #1;
        chk("async_reset cmd", oControlComms, 8'h00);
        chk("async_reset busy", oBusy, 0);
        chk("async_reset ct1", oChargeTime1, 0);
        @(negedge txCLK);
        txRESETn = 1'b1;
        repeat (5) @(negedge txCLK);
        chk("post_reset cmd", oControlComms, 8'h00);
        chk("post_reset busy", oBusy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
